rob_sequencer: RTL

Operand dispatcher and result collector wrapped around the `toprobertsons` 8-bit signed Robertson multiplier.
- Accepts operand pairs over a valid/ready stream into a small FIFO.
- Launches each multiply by pulsing the multiplier's reset/start input, waits for `done`, and captures the 16-bit product.
- Presents results in order on a valid/ready output stream, with a timeout guard against a hung multiplier.

---
 rtl/rob_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/rob_sequencer.sv
// rob_sequencer: operand dispatcher and result collector for an external 8-bit signed
// Robertson multiplier (toprobertsons).
//
// Operand pairs enter a small FIFO over a valid/ready stream. Each pair is launched by
// a one-cycle mul_start pulse, which drives the multiplier's reset/start input. The
// 16-bit product is captured when mul_done is seen, or replaced by 0 with out_error set
// if the multiplier hangs. Results leave in push order over a valid/ready stream.
//
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   in_valid/in_ready                   operand stream handshake
//   in_multiplier, in_multiplicand      signed 8-bit operands
//   mul_start                           start pulse to the multiplier
//   mul_multiplier, mul_multiplicand    operands held for the multiplier
//   mul_product, mul_done               multiplier result and completion flag
//   out_valid/out_ready                 result stream handshake
//   out_product, out_error              result (0 on timeout), timeout flag
//   busy, count                         activity flag, FIFO occupancy
module rob_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_multiplier,
  input  logic [7:0]               in_multiplicand,
  output logic                     mul_start,
  output logic [7:0]               mul_multiplier,
  output logic [7:0]               mul_multiplicand,
  input  logic [15:0]              mul_product,
  input  logic                     mul_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_product,
  output logic                     out_error,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] DepthC    = CW'(DEPTH);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StGuard = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          mul_start_q, mul_start_d;
  logic [7:0]    mul_a_q, mul_a_d;
  logic [7:0]    mul_b_q, mul_b_d;
  logic [15:0]   out_product_q, out_product_d;
  logic          out_error_q, out_error_d;

  logic [15:0]   mem_q [DEPTH];
  logic          push;
  logic          pop;
  logic [15:0]   head;

  // Full is judged on the registered count, so a pop in the same cycle never frees a slot.
  assign in_ready = (count_q != DepthC);
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    timer_d       = timer_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    out_product_d = out_product_q;
    out_error_d   = out_error_q;

    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: state_d = StGuard;
      StGuard: begin
        // mul_done may still be high from the previous op; it is not looked at here.
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        if (mul_done) begin
          out_product_d = mul_product;
          out_error_d   = 1'b0;
          state_d       = StHold;
        end else if (timer_q == TimerLast) begin
          out_product_d = '0;
          out_error_d   = 1'b1;
          state_d       = StHold;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StHold: begin
        if (out_ready) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      mul_a_d = head[15:8];
      mul_b_d = head[7:0];
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Registered so the pulse is a clean flop output that coincides with StStart.
    mul_start_d = (state_d == StStart);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      mul_start_q   <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      out_product_q <= '0;
      out_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      mul_start_q   <= mul_start_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      out_product_q <= out_product_d;
      out_error_q   <= out_error_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_multiplier, in_multiplicand};
    end
  end

  assign mul_start        = mul_start_q;
  assign mul_multiplier   = mul_a_q;
  assign mul_multiplicand = mul_b_q;
  assign out_valid        = (state_q == StHold);
  assign out_product      = out_product_q;
  assign out_error        = out_error_q;
  assign busy             = (state_q != StIdle) || (count_q != '0);
  assign count            = count_q;

endmodule
